charge_input_controller: RTL and testbench
==========================================

// Module: charge_input_controller
// PURPOSE
//  Writer side of the charge_bar interface: turns the raw jump button into the charge_bar value consumed by the
//  7-seg charge display, and issues one jump request (valid/ready) carrying the final charge on release.
//  Sits between the board button pin and the physics/jump logic; charge_bar fans out to display and physics.
// PARAMETERS
//  PHY_WIDTH        16       width of charge_bar / jump_power
//  DEBOUNCE_CYCLES  100_000  sys_clk cycles button must be stable before a level change is accepted
//  CHARGE_TICK      50_000   sys_clk cycles per +1 charge increment
//  MAX_CHARGE       495      saturation value of charge_bar (9 display steps of 55)
//  COOLDOWN_CYCLES  2_000_000 sys_clk cycles after a jump before a new charge may start
// PORTS
//  sys_clk     in   1          system clock
//  sys_rst_n   in   1          asynchronous active-low reset
//  btn_raw     in   1          raw button, active-high, asynchronous to sys_clk
//  enable      in   1          charging permitted (e.g. player grounded)
//  jump_ready  in   1          consumer accepts jump request
//  charge_bar  out  PHY_WIDTH  live charge; 0 idle, 1 on charge start, saturates at MAX_CHARGE
//  charging    out  1          high in CHARGE state
//  jump_valid  out  1          jump request pending
//  jump_power  out  PHY_WIDTH  charge captured at release; stable while jump_valid
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, sync/debounce regs 0, counters 0.
//  - btn_raw -> 2-FF synchronizer -> debouncer; btn_stable changes only after DEBOUNCE_CYCLES equal samples;
//    press = rising edge, release = falling edge of btn_stable (1-cycle pulses).
//  - FSM IDLE/CHARGE/FIRE/COOLDOWN:
//    IDLE: press && enable -> CHARGE; charge_bar<=1, tick_cnt<=0. Press with enable=0 ignored (needs new press).
//    CHARGE: tick_cnt counts 0..CHARGE_TICK-1; on wrap charge_bar<=min(charge_bar+1,MAX_CHARGE).
//      release -> FIRE, jump_power<=charge_bar, jump_valid<=1 next cycle.
//      enable falls -> IDLE, charge_bar<=0, no jump (abort wins over same-cycle release).
//    FIRE: jump_valid held until jump_ready sampled high; on handshake -> COOLDOWN, jump_valid<=0, charge_bar<=0.
//      jump_power and charge_bar frozen while waiting; button activity ignored.
//    COOLDOWN: counts COOLDOWN_CYCLES then -> IDLE. Button held across end of cooldown does not start a charge.
//  - Latency: press edge -> charge_bar=1 next cycle; release edge -> jump_valid next cycle.
//  - charge_bar never exceeds MAX_CHARGE, never wraps; increment in PHY_WIDTH bits, compare before add.
//  - Async reset mid-operation: immediate return to reset values; pending jump is dropped.
// CONFIGURATION
//  CHARGE_AUTO_FIRE_EN defined: reaching MAX_CHARGE in CHARGE goes to FIRE immediately (jump_power=MAX_CHARGE);
//    the still-held button is then ignored until released and pressed again after COOLDOWN.
//  Undefined: charge_bar holds at MAX_CHARGE until release or abort.
// STRUCTURE
//  Shared package charge_pkg: state encoding (IDLE,CHARGE,FIRE,COOLDOWN), default MAX_CHARGE / THRESHOLD step 55,
//    so display and input sides agree on scaling.
//  Sub-module btn_debouncer (synchronizer + stable counter + press/release pulses); FSM and counters in top.
// TESTING  (sim params: DEBOUNCE_CYCLES=4, CHARGE_TICK=3, MAX_CHARGE=10, COOLDOWN_CYCLES=5)
//  1 Bounce 1-0-1 pulses shorter than 4 cycles -> btn_stable unchanged, charge_bar stays 0.
//  2 Press, hold 12 cycles after charge start, release -> charge_bar 1..5, jump_valid=1, jump_power=5.
//  3 Hold 60 cycles -> charge_bar saturates at 10, never 11; release -> jump_power=10 (macro off).
//  4 jump_ready low 7 cycles in FIRE -> jump_valid/jump_power stable; ready high -> 1-cycle handshake, charge_bar=0.
//  5 enable drops mid-charge at charge_bar=3 -> IDLE, charge_bar=0, no jump_valid ever.
//  6 CHARGE_AUTO_FIRE_EN, hold -> jump_valid when charge_bar hits 10; button held through COOLDOWN -> no recharge.

Source files
------------

// File: rtl/charge_pkg.sv
// Shared definitions for the charge_bar interface: FSM encoding and display scaling, so the
// input controller and the 7-seg display agree on how charge maps to display steps.
package charge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCharge,
        StFire,
        StCooldown
    } charge_state_e;

    localparam int unsigned ThresholdStep    = 55;
    localparam int unsigned DisplaySteps     = 9;
    localparam int unsigned DefaultMaxCharge = ThresholdStep * DisplaySteps;

    // Bits needed for a counter that runs 0..max(a,b)-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer plus stability counter for the raw jump button; emits one-cycle
// press/release pulses on edges of the debounced level.
module btn_debouncer
    import charge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d, stable_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronized level disagrees with the accepted one,
    // so any bounce back to the old level restarts the qualification window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_raw_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign press_o   = stable_q & ~stable_prev_q;
    assign release_o = ~stable_q & stable_prev_q;

endmodule

// File: rtl/charge_input_controller.sv
// Jump-button charge controller: builds charge_bar while the button is held and issues one
// valid/ready jump request on release. Define CHARGE_AUTO_FIRE_EN to fire automatically at MAX_CHARGE.
module charge_input_controller
    import charge_pkg::*;
#(
    parameter int unsigned PHY_WIDTH       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000,
    parameter int unsigned CHARGE_TICK     = 50_000,
    parameter int unsigned MAX_CHARGE      = DefaultMaxCharge,
    parameter int unsigned COOLDOWN_CYCLES = 2_000_000
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_ni,
    input  logic                 btn_raw_i,
    input  logic                 enable_i,
    input  logic                 jump_ready_i,
    output logic [PHY_WIDTH-1:0] charge_bar_o,
    output logic                 charging_o,
    output logic                 jump_valid_o,
    output logic [PHY_WIDTH-1:0] jump_power_o
);

    localparam int unsigned CntW = cnt_width(CHARGE_TICK, COOLDOWN_CYCLES);
    localparam logic [PHY_WIDTH-1:0] MaxCharge = PHY_WIDTH'(MAX_CHARGE);

    logic btn_press, btn_release;

    charge_state_e        state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [PHY_WIDTH-1:0] charge_q, charge_d, charge_inc;
    logic [PHY_WIDTH-1:0] power_q, power_d;
    logic                 valid_q, valid_d;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i    (sys_clk_i),
        .rst_ni   (sys_rst_ni),
        .btn_raw_i(btn_raw_i),
        .press_o  (btn_press),
        .release_o(btn_release)
    );

    // Compare before adding so the bar saturates instead of wrapping.
    assign charge_inc = (charge_q >= MaxCharge) ? MaxCharge : charge_q + 1'b1;

    // cnt is the charge tick divider in StCharge and the cooldown timer in StCooldown.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        charge_d = charge_q;
        power_d  = power_q;
        valid_d  = valid_q;
        case (state_q)
            StIdle: begin
                if (btn_press && enable_i) begin
                    state_d  = StCharge;
                    charge_d = PHY_WIDTH'(1);
                    cnt_d    = '0;
                end
            end
            StCharge: begin
                if (!enable_i) begin
                    state_d  = StIdle;
                    charge_d = '0;
                end else if (btn_release) begin
                    state_d = StFire;
                    power_d = charge_q;
                    valid_d = 1'b1;
                end else begin
                    if (cnt_q == CntW'(CHARGE_TICK - 1)) begin
                        cnt_d    = '0;
                        charge_d = charge_inc;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef CHARGE_AUTO_FIRE_EN
                    if (charge_d == MaxCharge) begin
                        state_d = StFire;
                        power_d = MaxCharge;
                        valid_d = 1'b1;
                    end
`endif
                end
            end
            StFire: begin
                if (jump_ready_i) begin
                    state_d  = StCooldown;
                    valid_d  = 1'b0;
                    charge_d = '0;
                    cnt_d    = '0;
                end
            end
            StCooldown: begin
                if (cnt_q == CntW'(COOLDOWN_CYCLES - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            charge_q <= '0;
            power_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            charge_q <= charge_d;
            power_q  <= power_d;
            valid_q  <= valid_d;
        end
    end

    assign charge_bar_o = charge_q;
    assign charging_o   = (state_q == StCharge);
    assign jump_valid_o = valid_q;
    assign jump_power_o = power_q;

endmodule

// File: tb/tb_charge_input_controller.sv
// Bench for charge_input_controller: directed scenarios plus randomized button/enable/ready
// traffic, all compared cycle by cycle against a behavioural model of the button/charge rules.
module tb_charge_input_controller;

    localparam int W    = 16;
    localparam int DEB  = 4;
    localparam int CT   = 3;
    localparam int MAXC = 10;
    localparam int COOL = 5;

    logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0, en = 1'b1, rdy = 1'b0;
    logic [W-1:0] charge_bar, jump_power;
    logic charging, jump_valid;
    int checks = 0, errors = 0, cyc = 0;

    charge_input_controller #(
        .PHY_WIDTH      (W),
        .DEBOUNCE_CYCLES(DEB),
        .CHARGE_TICK    (CT),
        .MAX_CHARGE     (MAXC),
        .COOLDOWN_CYCLES(COOL)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_ni  (rst_n),
        .btn_raw_i   (btn),
        .enable_i    (en),
        .jump_ready_i(rdy),
        .charge_bar_o(charge_bar),
        .charging_o  (charging),
        .jump_valid_o(jump_valid),
        .jump_power_o(jump_power)
    );

    always #5 clk = ~clk;

    // Reference model: raw sample history, debounced level, and the charge session as
    // "cycles since charge start" rather than a tick counter.
    bit hist[$];
    bit m_stable, m_press, m_release, m_charging, m_valid;
    int m_charge, m_power, m_elapsed, m_cool;

    function automatic logic [2*W+1:0] obs();
        return {charging, jump_valid, jump_power, charge_bar};
    endfunction

    function automatic logic [2*W+1:0] expv();
        return {m_charging, m_valid, W'(m_power), W'(m_charge)};
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
        m_stable = 0; m_press = 0; m_release = 0; m_charging = 0; m_valid = 0;
        m_charge = 0; m_power = 0; m_elapsed = 0; m_cool = 0;
    endtask

    task automatic model_update();
        bit pr, rl, old, w, eq;
        pr = m_press;
        rl = m_release;
        if (m_charging) begin
            if (!en) begin
                m_charging = 0; m_charge = 0;
            end else if (rl) begin
                m_charging = 0; m_valid = 1; m_power = m_charge;
            end else begin
                m_elapsed++;
                m_charge = 1 + m_elapsed / CT;
                if (m_charge > MAXC) m_charge = MAXC;
`ifdef CHARGE_AUTO_FIRE_EN
                if (m_charge == MAXC) begin
                    m_charging = 0; m_valid = 1; m_power = MAXC;
                end
`endif
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 0; m_charge = 0; m_cool = COOL;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (pr && en) begin
            m_charging = 1; m_charge = 1; m_elapsed = 0;
        end
        // Level accepted once the last DEB synchronized samples all agree.
        old = m_stable;
        w   = hist[hist.size() - 2];
        eq  = 1;
        for (int i = 0; i < DEB; i++) if (hist[hist.size() - 2 - i] != w) eq = 0;
        if (eq) m_stable = w;
        m_press   = m_stable & ~old;
        m_release = ~m_stable & old;
        hist.push_back(btn);
        if (hist.size() > DEB + 2) void'(hist.pop_front());
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        btn = 0; rdy = 1; en = 1; n = 0;
        while ((m_charging || m_valid || m_cool != 0 || m_stable || m_release) && n < 80) begin
            step(); n++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL settle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        checks++;
        if (n >= 80) begin
            errors++; $display("FAIL settle_timeout cyc=%0d got=%h want=idle", cyc, obs());
        end
        rdy = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", obs());
        end
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_bounce();
        int run;
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (run == 0) begin
                btn = ~btn; run = $urandom_range(1, DEB - 1);
            end
            run--;
            step();
            checks++;
            if (obs() !== expv() || charge_bar !== '0) begin
                errors++; $display("FAIL bounce cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_basic_jump();
        wait_idle();
        btn = 1;
        for (int i = 0; i < 20 && !m_charging; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL basic_press cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        checks++;
        if (charging !== 1'b1 || charge_bar !== W'(1)) begin
            errors++; $display("FAIL basic_start got chg=%b bar=%0d want chg=1 bar=1", charging, charge_bar);
        end
        // Release takes 6 edges to reach the FSM, so it acts at 13 edges after start (bar=5).
        for (int i = 0; i < 6; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL basic_hold cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        btn = 0;
        for (int i = 0; i < 20 && !m_valid; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL basic_release cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        checks++;
        if (jump_valid !== 1'b1 || jump_power !== W'(5)) begin
            errors++; $display("FAIL basic_power got val=%b pow=%0d want val=1 pow=5", jump_valid, jump_power);
        end
        rdy = 1;
        step(); checks++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL basic_handshake cyc=%0d got=%h want=%h", cyc, obs(), expv());
        end
        rdy = 0;
    endtask

    task automatic test_saturate();
        logic [W-1:0] maxbar;
        bit seen;
        maxbar = '0; seen = 0;
        wait_idle();
        btn = 1;
        for (int i = 0; i < 20 && !m_charging; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL sat_press cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
`ifndef CHARGE_AUTO_FIRE_EN
        for (int i = 0; i < 60; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL sat_hold cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (charge_bar > maxbar) maxbar = charge_bar;
        end
        checks++;
        if (maxbar !== W'(MAXC)) begin
            errors++; $display("FAIL sat_max got=%0d want=%0d", maxbar, MAXC);
        end
        btn = 0;
        for (int i = 0; i < 20 && !m_valid; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL sat_release cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        checks++;
        if (jump_valid !== 1'b1 || jump_power !== W'(MAXC)) begin
            errors++; $display("FAIL sat_power got val=%b pow=%0d want val=1 pow=%0d", jump_valid, jump_power, MAXC);
        end
        rdy = 1;
        step();
        rdy = 0;
`else
        for (int i = 0; i < 60 && !m_valid; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL auto_hold cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        checks++;
        if (jump_valid !== 1'b1 || jump_power !== W'(MAXC) || charge_bar !== W'(MAXC)) begin
            errors++; $display("FAIL auto_fire got val=%b pow=%0d bar=%0d want 1/%0d/%0d",
                               jump_valid, jump_power, charge_bar, MAXC, MAXC);
        end
        rdy = 1;
        step();
        rdy = 0;
        for (int i = 0; i < COOL + 15; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL auto_cool cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            seen |= charging;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL auto_held_recharge got charging=1 want 0");
        end
        btn = 0;
`endif
    endtask

    task automatic test_ready_stall();
        int p;
        wait_idle();
        btn = 1;
        for (int i = 0; i < 20 && !m_charging; i++) step();
        repeat (3) step();
        btn = 0;
        for (int i = 0; i < 20 && !m_valid; i++) step();
        p = m_power;
        btn = 1;  // button activity in FIRE must be ignored
        for (int i = 0; i < 7; i++) begin
            step(); checks++;
            if (obs() !== expv() || {jump_valid, jump_power} !== {1'b1, W'(p)}) begin
                errors++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        rdy = 1;
        step(); checks++;
        if (jump_valid !== 1'b0 || charge_bar !== '0 || obs() !== expv()) begin
            errors++; $display("FAIL stall_handshake got val=%b bar=%0d want val=0 bar=0", jump_valid, charge_bar);
        end
        rdy = 0;
        step(); checks++;
        if (jump_valid !== 1'b0 || obs() !== expv()) begin
            errors++; $display("FAIL stall_after got val=%b want 0", jump_valid);
        end
    endtask

    task automatic test_abort();
        bit seen;
        seen = 0;
        wait_idle();
        btn = 1;
        for (int i = 0; i < 20 && !m_charging; i++) step();
        for (int i = 0; i < 20 && m_charge != 3; i++) step();
        en = 0;
        step(); checks++;
        if (charge_bar !== '0 || charging !== 1'b0 || obs() !== expv()) begin
            errors++; $display("FAIL abort got chg=%b bar=%0d want chg=0 bar=0", charging, charge_bar);
        end
        btn = 0;
        for (int i = 0; i < 15; i++) begin
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL abort_after cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            seen |= jump_valid;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_jump got jump_valid=1 want 0");
        end
        // Release and enable-drop hitting the FSM on the same edge: abort must win.
        wait_idle();
        btn = 1;
        for (int i = 0; i < 20 && !m_charging; i++) step();
        repeat (3) step();
        btn = 0;
        repeat (6) step();
        en = 0;
        step(); checks++;
        if (jump_valid !== 1'b0 || charge_bar !== '0 || obs() !== expv()) begin
            errors++; $display("FAIL abort_vs_release got val=%b bar=%0d want 0/0", jump_valid, charge_bar);
        end
        // Press while disabled is ignored even if enable returns with the button held.
        wait_idle();
        en = 0; btn = 1; seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) en = 1;
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL disabled_press cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            seen |= charging;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL disabled_press_charge got charging=1 want 0");
        end
        btn = 0;
    endtask

    task automatic test_random();
        int run;
        run = 0;
        wait_idle();
        for (int i = 0; i < 2500; i++) begin
            if (run == 0) begin
                btn = ~btn; run = $urandom_range(1, 14);
            end
            run--;
            en  = ($urandom_range(0, 99) < 97);
            rdy = $urandom_range(0, 1);
            step(); checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        wait_idle();
        btn = 1;
        for (int i = 0; i < 20 && !m_charging; i++) step();
        repeat (2) step();
        btn = 0;
        for (int i = 0; i < 20 && !m_valid; i++) step();
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++; $display("FAIL async_reset got=%h want=0", obs());
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        rdy = 1;
        for (int i = 0; i < 10; i++) begin
            step(); checks++;
            if (obs() !== expv() || jump_valid !== 1'b0) begin
                errors++; $display("FAIL async_after cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        rdy = 0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_basic_jump();
        test_saturate();
        test_ready_stall();
        test_abort();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
